// File: rtl/ldl_parity_insert.sv
// ldl_parity_insert: per-flow XOR parity appender for the beat-based multi-flow datapath.
// Each packet's payload bytes are folded into PAR_BYTES lanes by byte position; the lanes
// are written right after the last payload byte, spilling into one extra beat when needed.

// One output byte position: masks bytes beyond the payload end out of the fold and
// substitutes the matching parity lane (or zero) on the payload-last beat.
module ldl_parity_byte #(
    parameter int K           = 0,
    parameter int PAR_BYTES   = 4,
    parameter int LENGTH_BITS = 15
) (
    input  logic [7:0]                din_byte,
    input  logic [LENGTH_BITS-1:0]    r,
    input  logic                      is_last,
    input  logic [PAR_BYTES-1:0][7:0] par,
    output logic [7:0]                fold_byte,
    output logic [7:0]                out_byte
);
    localparam int PIW = (PAR_BYTES > 1) ? $clog2(PAR_BYTES) : 1;
    localparam logic [LENGTH_BITS:0] KW = (LENGTH_BITS+1)'(K);
    localparam logic [LENGTH_BITS:0] PW = (LENGTH_BITS+1)'(PAR_BYTES);

    // offset of this byte past the payload end; only meaningful when K >= r
    logic [LENGTH_BITS:0] off;
    assign off = KW - {1'b0, r};

    // past the payload end: excluded from the fold, replaced by parity lane or zero
    always_comb begin
        fold_byte = din_byte;
        out_byte  = din_byte;
        if (is_last && (KW >= {1'b0, r})) begin
            fold_byte = 8'h00;
            out_byte  = (off < PW) ? par[off[PIW-1:0]] : 8'h00;
        end
    end
endmodule

module ldl_parity_insert #(
    parameter int PAR_BYTES   = 4,
    parameter int DATA_WIDTH  = 256,
    parameter int FLOW_NUM    = 8,
    parameter int LENGTH_BITS = 15,
    parameter int FID_W       = (FLOW_NUM > 1) ? $clog2(FLOW_NUM) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   vld_in,
    input  logic                   eop_in,
    input  logic [LENGTH_BITS-1:0] leng_in,
    input  logic [FID_W-1:0]       fid_in,
    input  logic [DATA_WIDTH-1:0]  din,
    output logic                   rdy,
    output logic [DATA_WIDTH-1:0]  dout,
    output logic [LENGTH_BITS-1:0] leng_out,
    output logic [FID_W-1:0]       fid_out,
    output logic                   vld_out,
    output logic                   eop_out,
    output logic                   err
);
    localparam int BYTE_NUM = DATA_WIDTH / 8;
    localparam logic [LENGTH_BITS-1:0] BN_L  = LENGTH_BITS'(BYTE_NUM);
    localparam logic [LENGTH_BITS-1:0] FIT_L = LENGTH_BITS'(BYTE_NUM - PAR_BYTES);
    localparam logic [LENGTH_BITS-1:0] PAR_L = LENGTH_BITS'(PAR_BYTES);

    typedef logic [PAR_BYTES-1:0][7:0] par_t;

    // per-flow framing and running parity
    logic [FLOW_NUM-1:0]                  sof;
    logic [FLOW_NUM-1:0][LENGTH_BITS-1:0] rem;
    par_t [FLOW_NUM-1:0]                  acc;

    // straddle spill: lanes that did not fit in the last beat, already shifted to lane 0
    logic                   pending;
    logic [FID_W-1:0]       pend_fid;
    logic [LENGTH_BITS-1:0] pend_len;
    par_t                   pend_par;

    logic                     accept;
    logic                     is_last;
    logic                     fit;
    logic                     err_nxt;
    logic [LENGTH_BITS-1:0]   r;
    logic [LENGTH_BITS-1:0]   n_lanes;
    par_t                     acc_cur;
    par_t                     beat_par;
    par_t                     par_new;
    par_t                     pend_nxt;
    logic [BYTE_NUM-1:0][7:0] fold_b;
    logic [DATA_WIDTH-1:0]    dout_proc;
    logic [DATA_WIDTH-1:0]    dout_ext;

    assign rdy     = !pending;
    assign accept  = vld_in & rdy & en;
    assign r       = sof[fid_in] ? leng_in : rem[fid_in];
    assign is_last = (r <= BN_L);
    assign fit     = (r <= FIT_L);
    assign acc_cur = sof[fid_in] ? '0 : acc[fid_in];
    assign par_new = acc_cur ^ beat_par;
    // lanes that still fit in the last beat; below PAR_BYTES only in the straddle case
    assign n_lanes = BN_L - r;
    assign err_nxt = (vld_in & !rdy) | (accept & (eop_in != is_last));
    // dropping the lanes already emitted leaves the remainder starting at lane 0
    assign pend_nxt = par_t'(par_new >> {n_lanes, 3'b000});

    for (genvar k = 0; k < BYTE_NUM; k++) begin : g_byte
        ldl_parity_byte #(
            .K           (k),
            .PAR_BYTES   (PAR_BYTES),
            .LENGTH_BITS (LENGTH_BITS)
        ) u_byte (
            .din_byte  (din[DATA_WIDTH-1-8*k -: 8]),
            .r         (r),
            .is_last   (is_last),
            .par       (par_new),
            .fold_byte (fold_b[k]),
            .out_byte  (dout_proc[DATA_WIDTH-1-8*k -: 8])
        );
    end

    // XOR-fold the masked beat into lanes by byte position modulo PAR_BYTES
    always_comb begin
        beat_par = '0;
        for (int k = 0; k < BYTE_NUM; k++)
            beat_par[k % PAR_BYTES] = beat_par[k % PAR_BYTES] ^ fold_b[k];
    end

    // extra beat: spilled lanes from byte 0, MSB-first, remainder zero
    always_comb begin
        dout_ext = '0;
        for (int i = 0; i < PAR_BYTES; i++)
            dout_ext[DATA_WIDTH-1-8*i -: 8] = pend_par[i];
    end

    // per-flow state advances only on accepted beats in insert mode
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sof <= '1;
            rem <= '0;
            acc <= '0;
        end else if (accept) begin
            if (is_last) begin
                // no beat can be accepted while the spill is out, so restarting here is safe
                sof[fid_in] <= 1'b1;
                acc[fid_in] <= '0;
            end else begin
                sof[fid_in] <= 1'b0;
                rem[fid_in] <= r - BN_L;
                acc[fid_in] <= par_new;
            end
        end
    end

    // spill register: loaded by a straddling last beat, drained the following cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending  <= 1'b0;
            pend_fid <= '0;
            pend_len <= '0;
            pend_par <= '0;
        end else if (pending) begin
            pending <= 1'b0;
        end else if (accept && is_last && !fit) begin
            pending  <= 1'b1;
            pend_fid <= fid_in;
            pend_len <= leng_in + PAR_L;
            pend_par <= pend_nxt;
        end
    end

    // output register: spill beat, bypass copy, processed beat, or idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout     <= '0;
            leng_out <= '0;
            fid_out  <= '0;
            vld_out  <= 1'b0;
            eop_out  <= 1'b0;
            err      <= 1'b0;
        end else begin
            err <= err_nxt;
            if (pending) begin
                dout     <= dout_ext;
                leng_out <= pend_len;
                fid_out  <= pend_fid;
                vld_out  <= 1'b1;
                eop_out  <= 1'b1;
            end else if (!en) begin
                dout     <= din;
                leng_out <= leng_in;
                fid_out  <= fid_in;
                vld_out  <= vld_in;
                eop_out  <= eop_in;
            end else if (accept) begin
                dout     <= dout_proc;
                leng_out <= leng_in + PAR_L;
                fid_out  <= fid_in;
                vld_out  <= 1'b1;
                // non-last beats never satisfy fit, so this is also the eop of a fitting packet
                eop_out  <= fit;
            end else begin
                vld_out <= 1'b0;
                eop_out <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_ldl_parity_insert.sv
// tb_ldl_parity_insert: random and directed packet stimulus; a packet-level parity model
// pushes expected beats into a queue that a negedge monitor drains against the DUT.
module tb_ldl_parity_insert;
    localparam int P  = 4;
    localparam int DW = 256;
    localparam int BN = DW / 8;
    localparam int FN = 8;
    localparam int LB = 15;
    localparam int FW = 3;

    logic          clk = 1'b0;
    logic          rst, en, vld_in, eop_in;
    logic [LB-1:0] leng_in;
    logic [FW-1:0] fid_in;
    logic [DW-1:0] din;
    logic          rdy, vld_out, eop_out, err;
    logic [DW-1:0] dout;
    logic [LB-1:0] leng_out;
    logic [FW-1:0] fid_out;

    ldl_parity_insert #(.PAR_BYTES(P), .DATA_WIDTH(DW), .FLOW_NUM(FN), .LENGTH_BITS(LB)) dut (
        .clk(clk), .rst(rst), .en(en), .vld_in(vld_in), .eop_in(eop_in), .leng_in(leng_in),
        .fid_in(fid_in), .din(din), .rdy(rdy), .dout(dout), .leng_out(leng_out),
        .fid_out(fid_out), .vld_out(vld_out), .eop_out(eop_out), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] d;
        logic [FW-1:0] fid;
        logic [LB-1:0] len;
        logic          eop;
        logic          err;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    // model state: payload bytes collected so far, beats seen, open packet length (0 = idle)
    logic [7:0] pay [FN][1024];
    int         nbeat [FN];
    int         curl [FN];

    task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] rnd_beat();
        logic [DW-1:0] v;
        for (int i = 0; i < DW / 32; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    // mode 1: byte k = base+k; mode 2: every byte 0x01
    function automatic logic [DW-1:0] pat(input int mode, input int base);
        logic [DW-1:0] v;
        for (int k = 0; k < BN; k++) v[DW-1-8*k -: 8] = (mode == 1) ? 8'(base + k) : 8'h01;
        return v;
    endfunction

    // packet-level reference: the output stream is payload ++ parity, cut into beats
    task automatic model_beat(input int f, input int L, input logic [DW-1:0] d,
                              input logic eop, input logic drop, output logic strad);
        int         base, nout;
        logic       last;
        logic [7:0] pk [1100];
        logic [7:0] par [P];
        exp_t       e;
        base = nbeat[f] * BN;
        last = (base + BN >= L);
        for (int k = 0; k < BN; k++) if (base + k < L) pay[f][base+k] = d[DW-1-8*k -: 8];
        strad = 1'b0;
        e.fid = FW'(f);
        e.len = LB'(L + P);
        if (!last) begin
            e.d = d; e.eop = 1'b0; e.err = (eop != last);
            sb.push_back(e);
            nbeat[f]++;
        end else begin
            for (int j = 0; j < P; j++) par[j] = 8'h00;
            for (int i = 0; i < L; i++) begin
                par[i % P] = par[i % P] ^ pay[f][i];
                pk[i] = pay[f][i];
            end
            for (int j = 0; j < P; j++) pk[L+j] = par[j];
            nout  = (L + P + BN - 1) / BN;
            strad = (nout > nbeat[f] + 1);
            for (int b = nbeat[f]; b < nout; b++) begin
                for (int k = 0; k < BN; k++)
                    e.d[DW-1-8*k -: 8] = (b * BN + k < L + P) ? pk[b*BN+k] : 8'h00;
                e.eop = (b == nout - 1);
                e.err = (b == nbeat[f]) ? (eop != last) : drop;
                sb.push_back(e);
            end
            nbeat[f] = 0;
            curl[f]  = 0;
        end
    endtask

    // one beat; flip corrupts eop_in, drop presents a junk beat in the rdy-low cycle
    task automatic send(input int f, input int L, input logic [DW-1:0] d,
                        input logic flip, input logic drop);
        int   t;
        logic last, strad;
        t = 0;
        while (!rdy && t < 20) begin @(posedge clk); #1; t++; end
        if (!rdy) begin checks++; errors++; $display("FAIL rdy_timeout rdy=%0b exp=1", rdy); end
        last    = (nbeat[f] * BN + BN >= L);
        vld_in  = 1'b1;
        eop_in  = last ^ flip;
        leng_in = LB'(L);
        fid_in  = FW'(f);
        din     = d;
        model_beat(f, L, d, last ^ flip, drop, strad);
        @(posedge clk); #1;
        chk("rdy_after_beat", DW'(rdy), DW'(!strad));
        if (strad && drop) begin
            din     = rnd_beat();
            fid_in  = FW'($urandom);
            leng_in = LB'($urandom);
            eop_in  = 1'($urandom);
            @(posedge clk); #1;
            chk("rdy_after_spill", DW'(rdy), DW'(1));
        end
        vld_in = 1'b0;
        eop_in = 1'b0;
    endtask

    task automatic send_pkt(input int f, input int L, input int mode, input logic flip, input logic drop);
        int nb;
        nb = (L + BN - 1) / BN;
        for (int b = 0; b < nb; b++)
            send(f, L, (mode == 0) ? rnd_beat() : pat(mode, b * BN), flip && (b == 0), drop && (b == nb - 1));
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 50) begin @(posedge clk); #1; t++; end
        chk("drain_outstanding", DW'(sb.size()), DW'(0));
        sb.delete();
    endtask

    // monitor: every valid output beat must match the next expected beat
    always @(negedge clk) begin
        if (!rst) begin
            if (vld_out) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_beat fid=%0d eop=%0b d=%h", fid_out, eop_out, dout);
                end else begin
                    mon_e = sb.pop_front();
                    if (dout !== mon_e.d || fid_out !== mon_e.fid || leng_out !== mon_e.len ||
                        eop_out !== mon_e.eop || err !== mon_e.err) begin
                        errors++;
                        $display("FAIL beat got fid=%0d len=%0d eop=%0b err=%0b d=%h exp fid=%0d len=%0d eop=%0b err=%0b d=%h",
                                 fid_out, leng_out, eop_out, err, dout,
                                 mon_e.fid, mon_e.len, mon_e.eop, mon_e.err, mon_e.d);
                    end
                end
            end else if (err) begin
                checks++;
                errors++;
                $display("FAIL err_without_beat err=%0b exp=0", err);
            end
        end
    end

    initial begin
        rst = 1'b1; en = 1'b1; vld_in = 1'b0; eop_in = 1'b0;
        leng_in = '0; fid_in = '0; din = '0;
        for (int f = 0; f < FN; f++) begin nbeat[f] = 0; curl[f] = 0; end
        #7;
        chk("reset_dout", dout, '0);
        chk("reset_vld", DW'(vld_out), DW'(0));
        chk("reset_eop_err", DW'({eop_out, err}), DW'(0));
        chk("reset_leng_fid", DW'({leng_out, fid_out}), DW'(0));
        chk("reset_rdy", DW'(rdy), DW'(1));
        @(posedge clk); #1;
        rst = 1'b0;

        send_pkt(0, 8, 1, 1'b0, 1'b0);    // fit
        send_pkt(1, 30, 2, 1'b0, 1'b0);   // straddle
        send_pkt(0, 64, 0, 1'b0, 1'b0);   // exact fill, all lanes spill
        send_pkt(2, 33, 0, 1'b0, 1'b0);
        send_pkt(3, 1, 0, 1'b0, 1'b0);
        send_pkt(3, 28, 0, 1'b0, 1'b0);   // fills the beat exactly with parity
        drain();

        // flows 2 and 5 interleaved beat by beat
        for (int rep = 0; rep < 3; rep++) begin
            send(2, 40, rnd_beat(), 1'b0, 1'b0);
            send(5, 20, rnd_beat(), 1'b0, 1'b0);
            send(2, 40, rnd_beat(), 1'b0, 1'b0);
            send(5, 20, rnd_beat(), 1'b0, 1'b0);
        end
        drain();

        send_pkt(6, 30, 0, 1'b0, 1'b1);   // beat presented while rdy=0
        send_pkt(7, 40, 0, 1'b1, 1'b0);   // eop_in on first beat of L=40
        drain();

        for (int it = 0; it < 300; it++) begin
            int f;
            f = $urandom_range(0, FN - 1);
            if (curl[f] == 0) curl[f] = $urandom_range(1, 130);
            send(f, curl[f], rnd_beat(), $urandom_range(0, 15) == 0, $urandom_range(0, 3) == 0);
        end
        for (int f = 0; f < FN; f++)
            while (curl[f] != 0) send(f, curl[f], rnd_beat(), 1'b0, 1'b0);
        drain();

        // reset mid-packet on flow 4 and while flow 3's spill is pending
        send(4, 40, rnd_beat(), 1'b0, 1'b0);
        send(3, 30, rnd_beat(), 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        chk("midrst_dout", dout, '0);
        chk("midrst_vld_eop_err", DW'({vld_out, eop_out, err}), DW'(0));
        chk("midrst_leng_fid", DW'({leng_out, fid_out}), DW'(0));
        chk("midrst_rdy", DW'(rdy), DW'(1));
        sb.delete();
        for (int f = 0; f < FN; f++) begin nbeat[f] = 0; curl[f] = 0; end
        @(posedge clk); #1;
        rst = 1'b0;
        send_pkt(4, 8, 1, 1'b0, 1'b0);
        send_pkt(3, 40, 0, 1'b0, 1'b0);
        drain();

        // bypass: straight one-cycle copy
        en = 1'b0;
        for (int i = 0; i < 40; i++) begin
            exp_t e;
            vld_in  = 1'($urandom);
            eop_in  = 1'($urandom);
            leng_in = LB'($urandom);
            fid_in  = FW'($urandom);
            din     = rnd_beat();
            if (vld_in) begin
                e.d = din; e.fid = fid_in; e.len = leng_in; e.eop = eop_in; e.err = 1'b0;
                sb.push_back(e);
            end
            @(posedge clk); #1;
            chk("bypass_rdy", DW'(rdy), DW'(1));
        end
        vld_in = 1'b0;
        eop_in = 1'b0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
